// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - streams host words into the instruction RAM while holding the core in reset
// Optional trailing XOR checksum word is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    input  logic [A:0]   Count,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         CoreHold,
    output logic         Done,
    output logic         Err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    localparam logic [A:0] CNT_ONE = (A+1)'(1);

    state_t         state_q;
    logic           in_ready_q;
    logic           wr_en_q;
    logic [A-1:0]   wr_addr_q;
    logic [W-1:0]   wr_data_q;
    logic           busy_q;
    logic           done_q;
    logic [A-1:0]   addr_q;
    logic [A:0]     remaining_q;
`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0]   xor_q;
    logic           err_q;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        addr_q      <= StartAddr;
                        remaining_q <= Count;
                        busy_q      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        xor_q       <= '0;
                        err_q       <= 1'b0;
`endif
                        if (Count != '0) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            // An empty program still carries a checksum word (of value 0).
                            state_q    <= CHECK;
                            in_ready_q <= 1'b1;
`else
                            state_q    <= DONE;
                            done_q     <= 1'b1;
`endif
                        end
                    end
                end
                LOAD: begin
                    if (InValid) begin
                        wr_en_q     <= 1'b1;
                        wr_addr_q   <= addr_q;
                        wr_data_q   <= InData;
                        addr_q      <= addr_q + A'(1);
                        remaining_q <= remaining_q - CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                        xor_q       <= xor_q ^ InData;
                        if (remaining_q == CNT_ONE) begin
                            state_q <= CHECK;
                        end
`else
                        if (remaining_q == CNT_ONE) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (InValid) begin
                        state_q    <= DONE;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= (InData != xor_q);
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign InReady  = in_ready_q;
    assign WrEn     = wr_en_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;
    assign Busy     = busy_q;
    assign CoreHold = busy_q;
    assign Done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign Err      = err_q;
`else
    assign Err      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - self-checking bench for inst_mem_loader (both LOADER_CHECKSUM_EN builds)
module tb_inst_mem_loader;
    localparam int A = 10;
    localparam int W = 9;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [A-1:0] StartAddr;
    logic [A:0]   Count;
    logic         InValid;
    logic [W-1:0] InData;
    logic         InReady, WrEn, Busy, CoreHold, Done, Err;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;

    inst_mem_loader #(.A(A), .W(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr), .Count(Count),
        .InValid(InValid), .InData(InData), .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .Busy(Busy), .CoreHold(CoreHold), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int    tests = 0;
    int    fails = 0;
    string label = "reset";

    // Expected outputs for the current cycle, advanced from the load rules each cycle.
    logic         e_ready, e_busy, e_done, e_wren, e_err;
    logic [A-1:0] e_waddr;
    logic [W-1:0] e_wdata;
    logic [A-1:0] m_base;
    int           m_cnt, m_acc;
    logic [W-1:0] m_xor;

    bit           last_xfer;
    int           dut_writes, dut_dones;
    logic [A-1:0] dut_last_addr;
    logic [W-1:0] ram [0:(1<<A)-1];
    logic [W-1:0] wq[$];

    typedef struct {
        logic [A-1:0]         sa;
        int                   cnt;
        int                   vmode;
        logic [3:0][W-1:0]    w;
        int                   exp_nwr;
        logic [A-1:0]         exp_last;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        e_ready = 0; e_busy = 0; e_done = 0; e_wren = 0; e_err = 0;
        e_waddr = '0; e_wdata = '0; m_base = '0; m_cnt = 0; m_acc = 0; m_xor = '0;
    endtask

    task automatic tick();
        int a;
        @(negedge Clk);
        check({label, " ctl"}, {InReady, WrEn, Busy, CoreHold, Done, Err},
              {e_ready, e_wren, e_busy, e_busy, e_done, e_err});
        if (e_wren) begin
            check({label, " waddr"}, WrAddr, e_waddr);
            check({label, " wdata"}, WrData, e_wdata);
        end
        if (WrEn) begin
            dut_writes++;
            dut_last_addr = WrAddr;
            ram[WrAddr] = WrData;
        end
        if (Done) dut_dones++;
        last_xfer = InValid && InReady;
        e_wren = 0;
        if (e_done) begin
            e_done = 0;
            e_busy = 0;
        end else if (!e_busy) begin
            if (Start) begin
                m_base = StartAddr; m_cnt = int'(Count); m_acc = 0; m_xor = '0;
                e_err = 0; e_busy = 1;
                if (m_cnt + CK == 0) e_done = 1;
                else e_ready = 1;
            end
        end else if (e_ready && InValid) begin
            if (m_acc < m_cnt) begin
                a = (int'(m_base) + m_acc) % (1 << A);
                e_wren = 1; e_waddr = a[A-1:0]; e_wdata = InData;
                m_xor = m_xor ^ InData;
            end else begin
                e_err = (InData != m_xor);
            end
            m_acc++;
            if (m_acc == m_cnt + CK) begin
                e_ready = 0;
                e_done = 1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    // vmode: 0 always valid, 1 valid pattern 1-0-0-1-1-0-1, 2 random gaps.
    task automatic run_load(input logic [A-1:0] sa, input int cnt, input int vmode,
                            input bit bad_ck, input bit noise);
        logic [W-1:0] sq[$];
        logic [W-1:0] ck;
        logic [6:0]   pat;
        int idx, cyc, c;
        bit v;
        pat = 7'b1011001;
        dut_writes = 0; dut_dones = 0;
        Start = 1; StartAddr = sa; Count = cnt[A:0]; InValid = 0;
        tick();
        Start = 0;
        sq = wq;
        ck = '0;
        foreach (wq[i]) ck = ck ^ wq[i];
        if (bad_ck) ck = ck ^ W'(1);
        if (CK == 1) sq.push_back(ck);
        idx = 0; cyc = 0;
        while (idx < sq.size() && cyc < 4000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[cyc % 7] : ($urandom_range(0, 9) < 7);
            InValid = v;
            InData = v ? sq[idx] : W'($urandom);
            if (noise) begin
                Start = ($urandom_range(0, 7) == 0);
                StartAddr = A'($urandom);
                Count = (A+1)'($urandom_range(0, 5));
            end
            tick();
            if (last_xfer) idx++;
            cyc++;
        end
        check({label, " words sent"}, idx, sq.size());
        InValid = 0; Start = 0;
        c = 0;
        while (e_busy && c < 50) begin
            tick();
            c++;
        end
        check({label, " drain"}, e_busy, 0);
        tick();
    endtask

    initial begin
        vec_t vecs[5];
        int n;
        logic [W-1:0] w;

        vecs[0] = '{sa: 10'd0,    cnt: 3, vmode: 0, w: {9'h000, 9'h1FF, 9'h124, 9'h000}, exp_nwr: 3, exp_last: 10'd2};
        vecs[1] = '{sa: 10'd100,  cnt: 4, vmode: 1, w: {9'h1C3, 9'h03C, 9'h155, 9'h0AA}, exp_nwr: 4, exp_last: 10'd103};
        vecs[2] = '{sa: 10'd1022, cnt: 4, vmode: 0, w: {9'h004, 9'h003, 9'h002, 9'h001}, exp_nwr: 4, exp_last: 10'd1};
        vecs[3] = '{sa: 10'd7,    cnt: 0, vmode: 0, w: {9'h0,   9'h0,   9'h0,   9'h0},   exp_nwr: 0, exp_last: 10'd0};
        vecs[4] = '{sa: 10'd1023, cnt: 1, vmode: 2, w: {9'h0,   9'h0,   9'h0,   9'h0AB}, exp_nwr: 1, exp_last: 10'd1023};

        for (int i = 0; i < (1 << A); i++) ram[i] = '0;
        Reset_n = 0; Start = 0; StartAddr = '0; Count = '0; InValid = 0; InData = '0;
        model_reset();
        #23;
        check("reset outputs", {InReady, WrEn, WrAddr, WrData, Busy, CoreHold, Done, Err}, 0);
        Reset_n = 1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            label = $sformatf("vec%0d", i);
            wq.delete();
            for (int j = 0; j < vecs[i].cnt; j++) wq.push_back(vecs[i].w[j]);
            run_load(vecs[i].sa, vecs[i].cnt, vecs[i].vmode, 1'b0, 1'b0);
            check({label, " nwrites"}, dut_writes, vecs[i].exp_nwr);
            check({label, " dones"}, dut_dones, 1);
            if (vecs[i].exp_nwr > 0) check({label, " last addr"}, dut_last_addr, vecs[i].exp_last);
            check({label, " err"}, Err, 0);
        end

        // Reset in the middle of a 5-word load, then a clean reload.
        label = "midreset";
        Start = 1; StartAddr = 10'd300; Count = 11'd5; InValid = 0;
        tick();
        Start = 0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            InValid = 1; InData = W'(9'h050 + n);
            tick();
            if (last_xfer) n++;
        end
        check("midreset words", n, 2);
        #2 Reset_n = 0;
        #1 check("midreset outputs", {InReady, WrEn, WrAddr, WrData, Busy, CoreHold, Done, Err}, 0);
        model_reset();
        InValid = 0;
        #1 Reset_n = 1;
        tick();
        label = "after reset";
        wq = '{9'h011, 9'h022, 9'h033};
        run_load(10'd300, 3, 0, 1'b0, 1'b0);
        check("after reset nwrites", dut_writes, 3);
        check("after reset ram", {ram[300], ram[301], ram[302]}, {9'h011, 9'h022, 9'h033});

`ifdef LOADER_CHECKSUM_EN
        label = "ck good";
        ram[202] = 9'h155;
        wq = '{9'h0F0, 9'h00F};
        run_load(10'd200, 2, 0, 1'b0, 1'b0);
        check("ck good err", Err, 0);
        label = "ck bad";
        run_load(10'd200, 2, 0, 1'b1, 1'b0);
        check("ck bad err", Err, 1);
        check("ck bad ram", {ram[200], ram[201], ram[202]}, {9'h0F0, 9'h00F, 9'h155});
        check("ck bad nwrites", dut_writes, 2);
`endif

        for (int i = 0; i < 25; i++) begin
            bit bad;
            int cnt;
            label = $sformatf("rand%0d", i);
            cnt = (i == 0) ? (1 << A) : $urandom_range(0, 8);
            bad = (CK == 1) && ($urandom_range(0, 1) == 1);
            wq.delete();
            for (int j = 0; j < cnt; j++) begin
                w = W'($urandom);
                wq.push_back(w);
            end
            run_load(A'($urandom_range(1015, 1023)), cnt, 2, bad, 1'b1);
            check({label, " nwrites"}, dut_writes, cnt);
            check({label, " dones"}, dut_dones, 1);
            check({label, " err"}, Err, bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
